// File: rtl/branch_history_table_if.sv
// ----------------------------------------------------------------------------
// branch_history_table_if
//   Bundles the fetch/decode lookup port, the execute-stage training port and
//   the status outputs of the bimodal branch predictor.
//
//   master : the pipeline side (drives lookup/update, observes prediction)
//   slave  : the predictor itself
//
//   lookup_valid      FD-stage instruction is a branch
//   lookup_pc[31:0]   PC of the FD-stage instruction
//   jump              prediction, 1 = taken
//   update_valid      X-stage branch resolved this cycle
//   update_pc[31:0]   PC of the resolved branch
//   update_taken      actual outcome, 1 = taken
//   update_mispredict checker flagged a misprediction for this branch
//   ready             table initialisation has completed
//   mispredict_count  saturating count of qualified mispredicts
// ----------------------------------------------------------------------------
interface branch_history_table_if;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        jump;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        update_mispredict;
    logic        ready;
    logic [15:0] mispredict_count;

    modport master (
        output lookup_valid, lookup_pc,
        output update_valid, update_pc, update_taken, update_mispredict,
        input  jump, ready, mispredict_count
    );

    modport slave (
        input  lookup_valid, lookup_pc,
        input  update_valid, update_pc, update_taken, update_mispredict,
        output jump, ready, mispredict_count
    );
endinterface

// File: rtl/branch_history_table.sv
// ----------------------------------------------------------------------------
// branch_history_table
//   Bimodal branch predictor: ENTRIES 2-bit saturating counters indexed by
//   pc[IDX_BITS+1:2]. Read combinationally at fetch/decode, trained one cycle
//   later when the execute stage resolves a branch. After reset an init walk
//   writes INIT_STATE into every entry (ENTRIES cycles) before ready rises.
//
//   clk   in   single clock, all state on posedge
//   rst   in   synchronous, active-high reset
//   bus   slave modport of branch_history_table_if (lookup, update, status)
// ----------------------------------------------------------------------------
module branch_history_table #(
    parameter int          ENTRIES    = 64,
    parameter int          IDX_BITS   = 6,
    parameter logic [1:0]  INIT_STATE = 2'b01
) (
    input  logic                    clk,
    input  logic                    rst,
    branch_history_table_if.slave   bus
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(ENTRIES - 1);

    logic [0:0]          state;
    logic [IDX_BITS-1:0] init_idx;
    logic [15:0]         mis_cnt;
    logic [1:0]          ctr [ENTRIES];

    logic [IDX_BITS-1:0] lookup_idx;
    logic [IDX_BITS-1:0] update_idx;
    logic                ready;
    logic                upd_apply;
    logic [1:0]          upd_cur;
    logic [1:0]          upd_next;
    logic [1:0]          lookup_ctr;

    // Tag-less table: only the index bits of each PC matter.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lookup_pc[31:IDX_BITS+2], bus.lookup_pc[1:0],
                              bus.update_pc[31:IDX_BITS+2], bus.update_pc[1:0]};

    assign lookup_idx = bus.lookup_pc[IDX_BITS+1:2];
    assign update_idx = bus.update_pc[IDX_BITS+1:2];
    assign ready      = (state == ST_RUN);

    // Reset wins over a same-cycle update; updates before ready are dropped.
    assign upd_apply  = ready & ~rst & bus.update_valid;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        upd_cur  = ctr[update_idx];
        upd_next = upd_cur;
        if (bus.update_taken) begin
            if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
        end else begin
            if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
        end
    end

    // Write-first bypass: a lookup hitting the entry being trained this cycle
    // sees the post-update value.
    always_comb begin
        lookup_ctr = ctr[lookup_idx];
        if (upd_apply && (lookup_idx == update_idx)) lookup_ctr = upd_next;
    end

    assign bus.jump             = ready & ~rst & bus.lookup_valid & lookup_ctr[1];
    assign bus.ready            = ready;
    assign bus.mispredict_count = mis_cnt;

    // NOTE: sequential state is written with non-blocking assignments so all
    // flops update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_idx <= '0;
            mis_cnt  <= '0;
        end else begin
            if (state == ST_INIT) begin
                init_idx <= init_idx + 1'b1;
                if (init_idx == LAST_IDX) state <= ST_RUN;
            end
            if (upd_apply && bus.update_mispredict && (mis_cnt != 16'hFFFF))
                mis_cnt <= mis_cnt + 16'd1;
        end
    end

    // NOTE: the counter array has no reset term; the init walk fills it after
    // reset, which keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT)
                ctr[init_idx] <= INIT_STATE;
            else if (upd_apply)
                ctr[update_idx] <= upd_next;
        end
    end

endmodule

// File: tb/tb_branch_history_table.sv
// ----------------------------------------------------------------------------
// tb_branch_history_table
//   Directed bench for branch_history_table. Expected values are queued when
//   stimulus is driven and popped when the corresponding output is sampled.
// ----------------------------------------------------------------------------
module tb_branch_history_table;

    logic clk;
    logic rst;

    branch_history_table_if bus ();

    branch_history_table #(
        .ENTRIES    (64),
        .IDX_BITS   (6),
        .INIT_STATE (2'b01)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Drive a lookup away from the clock edge and sample jump on the negedge.
    task automatic look(input string tag, input logic [31:0] pc, input logic exp_jump);
        align();
        bus.lookup_valid = 1'b1;
        bus.lookup_pc    = pc;
        expect_val(tag, {31'd0, exp_jump});
        @(negedge clk);
        check({31'd0, bus.jump});
        bus.lookup_valid = 1'b0;
    endtask

    // One training update, applied on the next posedge.
    task automatic upd(input logic [31:0] pc, input logic taken, input logic mis);
        align();
        bus.update_valid      = 1'b1;
        bus.update_pc         = pc;
        bus.update_taken      = taken;
        bus.update_mispredict = mis;
        align();
        bus.update_valid      = 1'b0;
        bus.update_mispredict = 1'b0;
    endtask

    // Same-cycle lookup and update on the given PCs; jump sampled before the edge.
    task automatic bypass(input string tag, input logic [31:0] lpc, input logic [31:0] upc,
                          input logic taken, input logic exp_jump);
        align();
        bus.lookup_valid      = 1'b1;
        bus.lookup_pc         = lpc;
        bus.update_valid      = 1'b1;
        bus.update_pc         = upc;
        bus.update_taken      = taken;
        bus.update_mispredict = 1'b0;
        expect_val(tag, {31'd0, exp_jump});
        @(negedge clk);
        check({31'd0, bus.jump});
        align();
        bus.lookup_valid = 1'b0;
        bus.update_valid = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic exp_ready, input logic [15:0] exp_cnt);
        expect_val({tag, "_ready"}, {31'd0, exp_ready});
        check({31'd0, bus.ready});
        expect_val({tag, "_count"}, {16'd0, exp_cnt});
        check({16'd0, bus.mispredict_count});
    endtask

    // Count cycles until ready rises, bounded so a stuck FSM still terminates.
    task automatic wait_ready(input string tag, input int exp_cycles);
        int cnt;
        cnt = 0;
        while (bus.ready !== 1'b1 && cnt < 1000) begin
            align();
            cnt++;
        end
        expect_val(tag, exp_cycles);
        check(cnt);
    endtask

    task automatic sweep_not_taken(input string tag);
        for (int i = 0; i < 64; i++) look(tag, 32'(i) << 2, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                   = 1'b1;
        bus.lookup_valid      = 1'b1;
        bus.lookup_pc         = 32'h40;
        bus.update_valid      = 1'b0;
        bus.update_pc         = 32'h0;
        bus.update_taken      = 1'b0;
        bus.update_mispredict = 1'b0;

        // Reset state: jump held low while in reset.
        align();
        align();
        expect_val("reset_jump", 32'd0);
        check({31'd0, bus.jump});
        check_status("reset", 1'b0, 16'd0);
        bus.lookup_valid = 1'b0;
        rst = 1'b0;

        // 1 Init: ready low for exactly 64 cycles, every entry weakly not-taken.
        wait_ready("init_cycles", 64);
        sweep_not_taken("init_entry");

        // 2 Training on idx 16.
        upd(32'h40, 1'b1, 1'b0); look("train_t1", 32'h40, 1'b1);   // 01->10
        upd(32'h40, 1'b1, 1'b0); look("train_t2", 32'h40, 1'b1);   // 10->11
        upd(32'h40, 1'b0, 1'b0); look("train_n1", 32'h40, 1'b1);   // 11->10
        upd(32'h40, 1'b0, 1'b0); look("train_n2", 32'h40, 1'b0);   // 10->01
        upd(32'h40, 1'b0, 1'b0); look("train_n3", 32'h40, 1'b0);   // 01->00

        // 3 Saturation.
        repeat (5) upd(32'h0C, 1'b1, 1'b0);
        upd(32'h0C, 1'b0, 1'b0); look("sat_hi_back1", 32'h0C, 1'b1); // 11->10
        upd(32'h0C, 1'b0, 1'b0); look("sat_hi_back2", 32'h0C, 1'b0); // 10->01
        repeat (5) upd(32'h10, 1'b0, 1'b0);
        upd(32'h10, 1'b1, 1'b0); look("sat_lo_back1", 32'h10, 1'b0); // 00->01
        upd(32'h10, 1'b1, 1'b0); look("sat_lo_back2", 32'h10, 1'b1); // 01->10

        // 4 Bypass and aliasing on idx 16 (currently 00).
        upd(32'h40, 1'b1, 1'b0); look("byp_pre", 32'h40, 1'b0);      // 00->01
        bypass("byp_taken", 32'h40, 32'h40, 1'b1, 1'b1);             // 01->10 seen same cycle
        look("alias_140", 32'h140, 1'b1);
        bypass("byp_not_taken", 32'h140, 32'h40, 1'b0, 1'b0);        // 10->01 seen same cycle
        look("byp_post", 32'h40, 1'b0);
        bypass("byp_other_idx", 32'h44, 32'h40, 1'b1, 1'b0);         // idx 17 untouched, idx16 01->10
        look("byp_other_post", 32'h40, 1'b1);

        // Mispredict qualification.
        align();
        check_status("no_mis_yet", 1'b1, 16'd0);
        bus.update_mispredict = 1'b1;
        align();
        bus.update_mispredict = 1'b0;
        check_status("mis_without_valid", 1'b1, 16'd0);
        upd(32'h80, 1'b0, 1'b1);
        check_status("mis_qualified", 1'b1, 16'd1);

        // 5 Updates during init, reset pulsed mid-init.
        align();
        rst = 1'b1;
        align();
        rst = 1'b0;
        repeat (10) align();
        bus.update_valid      = 1'b1;
        bus.update_mispredict = 1'b1;
        bus.update_taken      = 1'b1;
        bus.update_pc         = 32'h40;
        repeat (10) align();
        check_status("init_upd_dropped", 1'b0, 16'd0);
        rst = 1'b1;
        align();
        rst = 1'b0;
        repeat (40) align();
        check_status("reinit_mid", 1'b0, 16'd0);
        bus.update_valid      = 1'b0;
        bus.update_mispredict = 1'b0;
        wait_ready("reinit_cycles", 24);
        check_status("reinit_done", 1'b1, 16'd0);
        sweep_not_taken("reinit_entry");
        upd(32'h40, 1'b1, 1'b0); look("reinit_idx16_is_01", 32'h40, 1'b1);
        upd(32'h10, 1'b1, 1'b0); look("reinit_idx4_is_01", 32'h10, 1'b1);

        // 6 Mispredict counter saturation.
        align();
        bus.update_valid      = 1'b1;
        bus.update_mispredict = 1'b1;
        bus.update_taken      = 1'b1;
        bus.update_pc         = 32'h40;
        repeat (65534) align();
        check_status("cnt_fffe", 1'b1, 16'hFFFE);
        align();
        check_status("cnt_ffff", 1'b1, 16'hFFFF);
        repeat (4465) align();
        bus.update_valid      = 1'b0;
        bus.update_mispredict = 1'b0;
        align();
        check_status("cnt_hold", 1'b1, 16'hFFFF);

        // lookup_valid=0 masks a strongly taken counter.
        bus.lookup_valid = 1'b0;
        bus.lookup_pc    = 32'h40;
        expect_val("no_valid_jump", 32'd0);
        @(negedge clk);
        check({31'd0, bus.jump});
        look("valid_jump", 32'h40, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
